// File: rtl/reset_seq_pkg.sv
// Shared definitions for the board reset sequencer: FSM encodings and
// small elaboration-time width helpers.
package reset_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a level debouncer: a new level is
// accepted only after it has been stable for DEBOUNCE_CYCLES cycles.
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned DB_W = width_for(DEBOUNCE_CYCLES);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: qualifies PLL/IDELAYCTRL lock and the user button,
// then releases per-subsystem resets one stage at a time.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned STAGE_GAP       = 4,
    parameter int unsigned NUM_STAGES      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button,
    input  logic                  pll_locked,
    input  logic                  ctrl_ready,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [STATE_W-1:0]    state
);

    localparam int unsigned CNT_W = width_for(max_u(HOLD_CYCLES, STAGE_GAP));
    localparam int unsigned STG_W = $clog2(NUM_STAGES) + 1;

    logic pll_s1, pll_s2;
    logic rdy_s1, rdy_s2;
    logic locks_s;
    logic btn_db;
    logic abort;
    logic hold_done;
    logic gap_done;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STG_W-1:0]      stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  ready_q, ready_d;

    // Lock inputs: plain two-flop synchronizers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_s1 <= 1'b0;
            pll_s2 <= 1'b0;
            rdy_s1 <= 1'b0;
            rdy_s2 <= 1'b0;
        end else begin
            pll_s1 <= pll_locked;
            pll_s2 <= pll_s1;
            rdy_s1 <= ctrl_ready;
            rdy_s2 <= rdy_s1;
        end
    end

    assign locks_s = pll_s2 & rdy_s2;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (button),
        .level(btn_db)
    );

    assign abort     = ~locks_s | btn_db;
    assign hold_done = (state_q == ST_HOLD)    && (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign gap_done  = (state_q == ST_RELEASE) && (cnt_q == CNT_W'(STAGE_GAP - 1));

    // State register; outputs are captured here so nothing leaves combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            stage_q   <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic; abort overrides every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (abort) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            stage_d = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        cnt_d   = '0;
                        stage_d = STG_W'(1);
                        state_d = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (gap_done) begin
                        cnt_d   = '0;
                        stage_d = stage_q + STG_W'(1);
                        if (stage_q == STG_W'(NUM_STAGES - 1)) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            endcase
        end
    end

    // Output logic; released bits only ever clear, re-assertion is via abort.
    always_comb begin
        rst_out_d = rst_out_q;
        ready_d   = (state_d == ST_RUN);
        if (abort) begin
            rst_out_d = '1;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    rst_out_d = '1;
                end
                ST_HOLD: begin
                    rst_out_d = '1;
                    if (hold_done) begin
                        rst_out_d[0] = 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (gap_done) begin
                        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                            if (STG_W'(i) == stage_q) begin
                                rst_out_d[i] = 1'b0;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    rst_out_d = '0;
                end
                default: begin
                    rst_out_d = '1;
                end
            endcase
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign state   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed, table-driven bench for reset_sequencer (HOLD 16, GAP 4, 3 stages, debounce 8).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       pll_locked;
    logic       ctrl_ready;
    logic [2:0] rst_out;
    logic       ready;
    logic [1:0] state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ecount   = 0;

    typedef struct {
        int unsigned at;
        logic [2:0]  rst_out;
        logic        ready;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[10];

    reset_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (16),
        .STAGE_GAP      (4),
        .NUM_STAGES     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .pll_locked(pll_locked),
        .ctrl_ready(ctrl_ready),
        .rst_out   (rst_out),
        .ready     (ready),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    // One clock edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        ecount++;
        @(negedge clk);
    endtask

    task automatic advance_to(input int unsigned n);
        while (ecount < n) step();
    endtask

    function automatic logic [31:0] outs();
        return 32'({rst_out, ready, state});
    endfunction

    task automatic run_table(input int unsigned offset, input string tag);
        for (int i = 0; i < 10; i++) begin
            advance_to(tbl[i].at + offset);
            check($sformatf("%s_e%0d", tag, tbl[i].at + offset), outs(),
                  32'({tbl[i].rst_out, tbl[i].ready, tbl[i].st}));
        end
    endtask

    initial begin
        int unsigned bad;

        // Release schedule relative to the edge after the lock inputs rise.
        tbl[0] = '{1,  3'b111, 1'b0, 2'd0};
        tbl[1] = '{2,  3'b111, 1'b0, 2'd0};
        tbl[2] = '{3,  3'b111, 1'b0, 2'd1};
        tbl[3] = '{18, 3'b111, 1'b0, 2'd1};
        tbl[4] = '{19, 3'b110, 1'b0, 2'd2};
        tbl[5] = '{22, 3'b110, 1'b0, 2'd2};
        tbl[6] = '{23, 3'b100, 1'b0, 2'd2};
        tbl[7] = '{26, 3'b100, 1'b0, 2'd2};
        tbl[8] = '{27, 3'b000, 1'b1, 2'd3};
        tbl[9] = '{28, 3'b000, 1'b1, 2'd3};

        rst = 1'b1; button = 1'b0; pll_locked = 1'b0; ctrl_ready = 1'b0;
        #1;
        check("reset_immediate", outs(), 32'({3'b111, 1'b0, 2'd0}));
        @(negedge clk); @(negedge clk);
        check("reset_held", outs(), 32'({3'b111, 1'b0, 2'd0}));

        // Power-up: locks present before the first edge after reset.
        pll_locked = 1'b1; ctrl_ready = 1'b1; rst = 1'b0; ecount = 0;
        run_table(0, "powerup");

        // Lock never arrives.
        rst = 1'b1; ctrl_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; ecount = 0; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (outs() !== 32'({3'b111, 1'b0, 2'd0})) bad++;
        end
        check("nolock_bad_cycles", 32'(bad), 32'd0);
        ctrl_ready = 1'b1; ecount = 0;
        run_table(0, "latelock");

        // Lock drop while running.
        pll_locked = 1'b0; ecount = 0;
        advance_to(2);
        check("drop_e2", outs(), 32'({3'b000, 1'b1, 2'd3}));
        advance_to(3);
        check("drop_e3", outs(), 32'({3'b111, 1'b0, 2'd0}));
        pll_locked = 1'b1; ecount = 0;
        run_table(0, "relock");

        // Short button glitches must not disturb RUN.
        bad = 0;
        for (int g = 0; g < 4; g++) begin
            button = 1'b1;
            repeat (3) begin step(); if (outs() !== 32'({3'b000, 1'b1, 2'd3})) bad++; end
            button = 1'b0;
            repeat (3) begin step(); if (outs() !== 32'({3'b000, 1'b1, 2'd3})) bad++; end
        end
        repeat (4) begin step(); if (outs() !== 32'({3'b000, 1'b1, 2'd3})) bad++; end
        check("glitch_bad_cycles", 32'(bad), 32'd0);

        // Held button: abort after 2 sync + 8 stable + 1 edges.
        button = 1'b1; ecount = 0;
        advance_to(10);
        check("btn_e10", outs(), 32'({3'b000, 1'b1, 2'd3}));
        advance_to(11);
        check("btn_e11", outs(), 32'({3'b111, 1'b0, 2'd0}));
        advance_to(20);
        check("btn_held_e20", outs(), 32'({3'b111, 1'b0, 2'd0}));
        button = 1'b0; ecount = 0;
        run_table(8, "btnrel");

        // Abort lands on the edge where bit 1 is due.
        pll_locked = 1'b0; ecount = 0;
        advance_to(3);
        check("mid_drop_e3", outs(), 32'({3'b111, 1'b0, 2'd0}));
        pll_locked = 1'b1; ecount = 0;
        advance_to(20);
        pll_locked = 1'b0;
        advance_to(22);
        check("mid_e22", outs(), 32'({3'b110, 1'b0, 2'd2}));
        advance_to(23);
        check("mid_e23", outs(), 32'({3'b111, 1'b0, 2'd0}));

        // Asynchronous reset in the middle of RELEASE.
        pll_locked = 1'b1; ecount = 0;
        advance_to(21);
        check("arst_pre", outs(), 32'({3'b110, 1'b0, 2'd2}));
        #1 rst = 1'b1;
        #1;
        check("arst_immediate", outs(), 32'({3'b111, 1'b0, 2'd0}));
        @(negedge clk);
        rst = 1'b0; ecount = 0;
        advance_to(2);
        check("arst_after_e2", outs(), 32'({3'b111, 1'b0, 2'd0}));
        advance_to(3);
        check("arst_after_e3", outs(), 32'({3'b111, 1'b0, 2'd1}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset controller sitting between the clock-generation primitives (PLL, IDELAYCTRL) and the rest of the design. It synchronizes PLL-lock, delay-controller-ready and the user reset button into the system clock domain, and debounces the button. It holds all downstream resets until the clocks are stable, then releases an ordered vector of per-subsystem resets one stage at a time. Any later loss of lock or button press re-asserts every reset.

## Interface
- `DEBOUNCE_CYCLES`, default 16'd50000: consecutive stable cycles needed to accept a change in the button level.
- `HOLD_CYCLES`, default 16: cycles all resets stay asserted after lock is qualified.
- `STAGE_GAP`, default 4: cycles between successive stage releases; must be ≥1.
- `NUM_STAGES`, default 3: number of reset outputs; must be ≥1.
- `clk  in  1`: system clock, the BUFG-driven CPU clock.
- `rst  in  1`: asynchronous, active-high reset of this block, driven from PLL-independent power-on logic.
- `button  in  1`: raw asynchronous push-button, active high.
- `pll_locked  in  1`: asynchronous PLL LOCKED.
- `ctrl_ready  in  1`: asynchronous IDELAYCTRL RDY.
- `rst_out  out  NUM_STAGES`: active-high reset per subsystem. Bit 0 is released first.
- `ready  out  1`: high only in RUN, when every `rst_out` bit is 0.
- `state  out  2`: current FSM state, for debug and LEDs.

## Operation
- **Input conditioning**
  - `pll_locked`, `ctrl_ready` and `button` each pass through a 2-flop synchronizer.
  - `locks_s` = sync(pll_locked) & sync(ctrl_ready).
  - Button debouncer holds an accepted level `btn_db` and a counter.
    - The counter resets to 0 whenever the synced button equals `btn_db`.
    - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1`, `btn_db` takes the synced level and the counter clears.
- **FSM states**
  - **WAIT_LOCK** (0): `rst_out` = all ones. Go to HOLD when `locks_s & ~btn_db`, with `cnt`=0.
  - **HOLD** (1): `rst_out` = all ones; `cnt` increments. On the edge where `cnt == HOLD_CYCLES-1`:
    - clear `rst_out[0]`;
    - set `stage` = 1 and `cnt` = 0;
    - go to RELEASE, or to RUN if `NUM_STAGES`==1.
  - **RELEASE** (2): `cnt` increments. On the edge where `cnt == STAGE_GAP-1`:
    - clear `rst_out[stage]`, increment `stage`, set `cnt` = 0;
    - if `stage` was `NUM_STAGES-1`, go to RUN on that same edge.
  - **RUN** (3): `rst_out` = 0, `ready` = 1. Stay here indefinitely.
- **Abort (highest priority, any state)**
  - If `~locks_s | btn_db`, the next state is WAIT_LOCK.
  - On that same edge: `rst_out` = all ones, `ready` = 0, `cnt` and `stage` = 0.
  - Holding the button keeps the block in WAIT_LOCK. Release begins only after the debounced button returns low.
- **Outputs**
  - `rst_out`, `ready` and `state` are all registered; there is no combinational path from any input.
  - Released stages never re-assert individually. Re-assertion happens only through abort, to all ones.
- **Widths**
  - `cnt` is wide enough for max(`HOLD_CYCLES`, `STAGE_GAP`).
  - `stage` is clog2(`NUM_STAGES`)+1 bits.
  - Counters must not wrap in any state.

## Timing
- Asynchronous `rst`=1 forces, immediately:
  - `state` = WAIT_LOCK, `rst_out` = all ones, `ready` = 0;
  - all synchronizer flops, `btn_db` and all counters = 0.
- Lock qualification latency: input change → `locks_s` after 2 edges → FSM reacts on edge 3.
- Abort latency from a lock drop: `rst_out` is all ones after edge 3.
- Abort latency from the button: 2 edges of sync + `DEBOUNCE_CYCLES` stable cycles + 1 edge.
- Release of bit k occurs `HOLD_CYCLES` + k·`STAGE_GAP` edges after HOLD entry.
- Lock drop on the same edge as a scheduled stage release: abort wins, and the bit stays 1.
- `rst` deassertion must be synchronous to `clk` upstream. This block does not re-synchronize `rst`.

## Structure
- Shared package `reset_seq_pkg` holds:
  - the state encodings `ST_WAIT_LOCK`=2'd0, `ST_HOLD`=2'd1, `ST_RELEASE`=2'd2, `ST_RUN`=2'd3;
  - the 2-bit state width constant.
- One sub-module `sync_debounce`: a 2-flop synchronizer plus the debouncer with `DEBOUNCE_CYCLES` as a parameter, instantiated for `button`.
- The lock inputs use plain 2-flop synchronizers inline.

## Test plan
All scenarios use `HOLD_CYCLES`=16, `STAGE_GAP`=4, `NUM_STAGES`=3, and `DEBOUNCE_CYCLES`=8 in simulation.

1. **Power-up:** `rst` pulse, then both locks raised before edge 1 → HOLD entered at edge 3; `rst_out` goes 3'b111 → 3'b110 at edge 19, 3'b100 at edge 23, 3'b000 at edge 27; `ready`=1 and `state`=3 at edge 27.
2. **Lock never arrives:** `pll_locked`=1, `ctrl_ready`=0 for 1000 cycles → `state`=0 and `rst_out`=3'b111 throughout.
3. **Lock drop in RUN:** `pll_locked` falls → `rst_out`=3'b111 and `ready`=0 after edge 3; lock restored → full release sequence repeats with identical timing.
4. **Button bounce:** 3-cycle glitches on `button` while in RUN → no change. Button held 20 cycles → abort once debounced; sequence restarts only after button low + 8 stable cycles.
5. **Abort mid-release:** lock drops so that `locks_s` falls on the edge bit 1 is due → `rst_out`=3'b111, never 3'b100.
6. **Async reset mid-RELEASE:** assert `rst` between edges → all outputs return to reset values immediately, with no clock edge required.
